// File: rtl/mux_arb_2x4_pkg.sv
// rtl/mux_arb_2x4_pkg.sv - shared state encodings, defaults and arbitration helpers
package mux_arb_2x4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    localparam int DEFAULT_WIDTH     = 4;
    localparam int DEFAULT_BURST_LEN = 4;
    localparam int BURST_CNT_W       = 4;

    // On a tie the requester that did not transfer last wins.
    function automatic logic pick_winner(input logic req0, input logic req1, input logic last);
        return req1 && (!req0 || !last);
    endfunction

    function automatic arb_state_e grant_state(input logic who);
        return who ? ST_GNT1 : ST_GNT0;
    endfunction

endpackage

// File: rtl/mux_2x1_4.sv
// rtl/mux_2x1_4.sv - 2:1 data mux, 4 bits wide by default
module mux_2x1_4 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? a1 : a0;

endmodule

// File: rtl/mux_arb_2x4.sv
// rtl/mux_arb_2x4.sv - two-requester round-robin arbiter over a shared mux (burst grants with MUX_ARB_BURST_EN)
module mux_arb_2x4
    import mux_arb_2x4_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       gnt0_q, gnt1_q, sel_q;
    logic       owner, own_req, oth_req, xfer;
    arb_state_e after_xfer;

`ifdef MUX_ARB_BURST_EN
    localparam logic [BURST_CNT_W-1:0] BURST_LEN_C = BURST_CNT_W'(BURST_LEN);
    logic [BURST_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    assign cnt_inc = cnt_q + 1'b1;
`else
    wire unused_burst_len = ^BURST_CNT_W'(BURST_LEN);
`endif

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign sel       = sel_q;
    assign out_valid = gnt0_q ? req0 : (gnt1_q ? req1 : 1'b0);
    assign xfer      = out_valid && out_ready;

    assign owner   = (state_q == ST_GNT1);
    assign own_req = owner ? req1 : req0;
    assign oth_req = owner ? req0 : req1;

    // Post-transfer hand-off: other side first, then own continuation, else idle.
    always_comb begin
        after_xfer = ST_IDLE;
        if (oth_req) begin
            after_xfer = grant_state(!owner);
        end else if (own_req) begin
            after_xfer = grant_state(owner);
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
`ifdef MUX_ARB_BURST_EN
        cnt_d   = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = grant_state(pick_winner(req0, req1, last_q));
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (xfer) begin
                    last_d = owner;
`ifdef MUX_ARB_BURST_EN
                    if (own_req && (cnt_inc < BURST_LEN_C)) begin
                        cnt_d = cnt_inc;
                    end else begin
                        state_d = after_xfer;
                    end
`else
                    state_d = after_xfer;
`endif
                end else if (!own_req) begin
                    state_d = oth_req ? grant_state(!owner) : ST_IDLE;
                end else begin
`ifdef MUX_ARB_BURST_EN
                    cnt_d = cnt_q;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            sel_q   <= 1'b0;
`ifdef MUX_ARB_BURST_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt0_q  <= (state_d == ST_GNT0);
            gnt1_q  <= (state_d == ST_GNT1);
            if (state_d == ST_GNT1) begin
                sel_q <= 1'b1;
            end else if (state_d == ST_GNT0) begin
                sel_q <= 1'b0;
            end
`ifdef MUX_ARB_BURST_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    mux_2x1_4 #(
        .WIDTH(WIDTH)
    ) u_mux (
        .a0  (data0),
        .a1  (data1),
        .sel (sel_q),
        .y   (out_data)
    );

endmodule

// File: tb/tb_mux_arb_2x4.sv
// tb/tb_mux_arb_2x4.sv - scoreboard bench for mux_arb_2x4 (burst case under MUX_ARB_BURST_EN)
module tb_mux_arb_2x4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [3:0] data0 = 4'h0;
    logic [3:0] data1 = 4'h0;
    logic       out_ready = 1'b0;
    logic       gnt0, gnt1, sel, out_valid;
    logic [3:0] out_data;

    int checks = 0;
    int failures = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    mux_arb_2x4 #(.WIDTH(4), .BURST_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .data0     (data0),
        .gnt0      (gnt0),
        .req1      (req1),
        .data1     (data1),
        .gnt1      (gnt1),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    // Monitor: every accepted beat must match the next expected {sel, data}.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("no_overlap", {31'd0, gnt0 & gnt1}, 32'd0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", {27'd0, sel, out_data}, 32'h1f);
                    end else begin
                        chk("beat", {27'd0, sel, out_data}, {27'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(2);
        chk("rst_gnt0", {31'd0, gnt0}, 0);
        chk("rst_gnt1", {31'd0, gnt1}, 0);
        chk("rst_sel", {31'd0, sel}, 0);
        chk("rst_valid", {31'd0, out_valid}, 0);
        rst = 1'b0;

        // Single requester, one beat, then withdraw to idle
        req0 = 1'b1; data0 = 4'hA; out_ready = 1'b1;
        exp_q.push_back({1'b0, 4'hA});
        chk("idle_latency_gnt0", {31'd0, gnt0}, 0);
        step(1);
        chk("single_gnt0", {31'd0, gnt0}, 1);
        chk("single_data", {28'd0, out_data}, 32'hA);
        chk("single_valid", {31'd0, out_valid}, 1);
        step(1);
        req0 = 1'b0;
        step(1);
        chk("single_idle_gnt0", {31'd0, gnt0}, 0);
        chk("single_idle_valid", {31'd0, out_valid}, 0);

        // Tie after reset alternates 3,C,3,C starting with requester 0
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 4'h3; data1 = 4'hC; out_ready = 1'b1;
        exp_q.push_back({1'b0, 4'h3});
        exp_q.push_back({1'b1, 4'hC});
        exp_q.push_back({1'b0, 4'h3});
        exp_q.push_back({1'b1, 4'hC});
        step(1);
        chk("tie_first_gnt0", {31'd0, gnt0}, 1);
        step(4);
        req0 = 1'b0; req1 = 1'b0;
        step(2);
        chk("tie_drain", exp_q.size(), 0);

        // GNT1 stalled for 5 cycles, then one transfer and hand-off to requester 0
        do_reset();
        req1 = 1'b1; data1 = 4'h5;
        step(1);
        req0 = 1'b1; data0 = 4'h9;
        for (int i = 0; i < 5; i++) begin
            chk("stall_gnt1", {31'd0, gnt1}, 1);
            chk("stall_sel", {31'd0, sel}, 1);
            chk("stall_data", {28'd0, out_data}, 32'h5);
            step(1);
        end
        out_ready = 1'b1;
        exp_q.push_back({1'b1, 4'h5});
        step(1);
        chk("stall_handoff_gnt0", {31'd0, gnt0}, 1);
        chk("stall_handoff_gnt1", {31'd0, gnt1}, 0);
        req0 = 1'b0; req1 = 1'b0;
        step(2);

        // Withdrawal in GNT0 hands over to requester 1 with no beat for 0
        do_reset();
        req0 = 1'b1; data0 = 4'h6;
        step(1);
        chk("wd_gnt0", {31'd0, gnt0}, 1);
        req0 = 1'b0; req1 = 1'b1; data1 = 4'h7; out_ready = 1'b1;
        exp_q.push_back({1'b1, 4'h7});
        step(1);
        chk("wd_gnt1", {31'd0, gnt1}, 1);
        chk("wd_gnt0_off", {31'd0, gnt0}, 0);
        step(1);
        req1 = 1'b0;
        step(1);
        chk("wd_idle_valid", {31'd0, out_valid}, 0);
        chk("idle_sel_hold", {31'd0, sel}, 1);
        chk("idle_data_hold", {28'd0, out_data}, 32'h7);

        // Reset during a pending GNT1 beat aborts it; next tie goes to requester 0
        do_reset();
        req1 = 1'b1; data1 = 4'hB;
        step(1);
        chk("rstmid_gnt1", {31'd0, gnt1}, 1);
        rst = 1'b1; out_ready = 1'b1;
        step(1);
        chk("rstmid_gnt0", {31'd0, gnt0}, 0);
        chk("rstmid_gnt1_off", {31'd0, gnt1}, 0);
        chk("rstmid_sel", {31'd0, sel}, 0);
        chk("rstmid_valid", {31'd0, out_valid}, 0);
        rst = 1'b0; req0 = 1'b1; data0 = 4'h2;
        exp_q.push_back({1'b0, 4'h2});
        step(1);
        chk("rstmid_tie_gnt0", {31'd0, gnt0}, 1);
        step(1);
        req0 = 1'b0; req1 = 1'b0;
        step(2);

`ifdef MUX_ARB_BURST_EN
        // Burst grants: 4 beats of each requester in turn
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 4'h3; data1 = 4'hC; out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back((r % 2 == 0) ? {1'b0, 4'h3} : {1'b1, 4'hC});
            end
        end
        step(13);
        req0 = 1'b0; req1 = 1'b0;
        step(2);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arb_2x4.md
MUX_ARB_2X4 -- requirements
Module: mux_arb_2x4

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set data width of both requester paths and the output.
REQ-002 Parameter BURST_LEN, default 4, SHALL set max accepted beats per grant when BURST_EN is defined (range 1..15).
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req0  input  1  requester 0 has a beat pending.
REQ-006 data0  input  WIDTH  requester 0 beat data.
REQ-007 gnt0  output  1  requester 0 owns the shared mux.
REQ-008 req1  input  1  requester 1 has a beat pending.
REQ-009 data1  input  WIDTH  requester 1 beat data.
REQ-010 gnt1  output  1  requester 1 owns the shared mux.
REQ-011 sel  output  1  mux select currently driven (0 = data0, 1 = data1).
REQ-012 out_data  output  WIDTH  muxed data of current owner.
REQ-013 out_valid  output  1  owner's beat is valid.
REQ-014 out_ready  input  1  downstream accepts the beat this cycle.

Function
REQ-015 FSM states IDLE, GNT0, GNT1; gnt0/gnt1/sel SHALL decode from registered state only, never from inputs.
REQ-016 IDLE: on any req sampled high, SHALL enter GNT of the winner at the next edge (1-cycle grant latency).
REQ-017 Winner: both requesting -> requester not equal to registered pointer `last`; single request -> that requester.
REQ-018 GNTx: sel = x, out_data = datax combinationally, out_valid = reqx.
REQ-019 Beat transfer SHALL occur exactly when out_valid && out_ready; `last` updates to x on transfer.
REQ-020 Requester SHALL hold req and data stable until transfer; a req dropped before transfer SHALL be treated as a withdrawal.
REQ-021 After transfer in GNTx (no BURST_EN): other req high -> GNT(other); else own req high -> stay GNTx; else IDLE.
REQ-022 reqx low in GNTx with no transfer: other req high -> GNT(other); else IDLE.
REQ-023 gnt0 and gnt1 SHALL never be high together; out_valid SHALL be 0 in IDLE.
REQ-024 sel SHALL retain its last value in IDLE, so out_data stays stable while idle.
REQ-025 Both reqs high continuously with out_ready=1 SHALL alternate grants one beat each (no starvation).

Reset
REQ-026 rst high at an edge SHALL force IDLE, gnt0=0, gnt1=0, sel=0, out_valid=0, last=1 (requester 0 wins first tie), burst count=0.
REQ-027 rst mid-transfer SHALL abort the grant with no beat counted; it overrides every other transition.

Configuration
REQ-028 Macro MUX_ARB_BURST_EN: when defined, a 4-bit burst counter SHALL count accepted beats in GNTx; owner keeps grant while own req high until BURST_LEN beats, then REQ-021 applies; counter clears on every grant change and in IDLE.
REQ-029 Without MUX_ARB_BURST_EN: counter absent, one beat per grant arbitration per REQ-021, BURST_LEN ignored.

Structure
REQ-030 Shared package SHALL hold state encodings (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and default WIDTH/BURST_LEN constants.
REQ-031 Datapath SHALL be one instance of the existing 4-bit 2:1 mux module mux_2x1_4 driven by sel; FSM in this module.

Verification
REQ-032 Reset then req0=1, data0=4'hA, out_ready=1 -> gnt0=1 next cycle, out_data=4'hA, out_valid=1; req0 drops -> IDLE.
REQ-033 req0=req1=1 same cycle after reset, data0=4'h3, data1=4'hC, out_ready=1 -> beats 3,C,3,C alternating; gnt0/gnt1 never overlap.
REQ-034 GNT1 with out_ready=0 for 5 cycles -> gnt1, sel=1, out_data=data1 held; out_ready=1 -> one transfer, then GNT0 if req0 high.
REQ-035 GNT0 holding, req0 dropped before out_ready, req1=1 -> GNT1 next cycle, no beat counted for requester 0.
REQ-036 rst asserted during GNT1 with pending beat -> IDLE, all outputs 0 next cycle; next tie grants requester 0.
REQ-037 With MUX_ARB_BURST_EN, BURST_LEN=4, both reqs high, out_ready=1 -> 4 beats of data0, then 4 of data1, repeating.
